ram_access_arbiter: RTL and testbench

RAM_ACCESS_ARBITER -- requirements
Module: ram_access_arbiter

---
 rtl/romulator_pkg.sv | 30 +++
 rtl/phi2_edge_sync.sv | 27 ++
 rtl/ram_access_arbiter.sv | 179 +++++++++++++++++
 tb/tb_ram_access_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/romulator_pkg.sv
// Shared definitions for the RAM access arbiter: FSM encoding, RAM owner codes
// and default parameter values.
package romulator_pkg;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    localparam logic [1:0] OWN_LOADER = 2'd0;
    localparam logic [1:0] OWN_CPU    = 2'd1;
    localparam logic [1:0] OWN_DIAG   = 2'd2;

    localparam int DEF_ADDR_W     = 16;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_NUM_WIN    = 2;
    localparam int DEF_HALT_EDGES = 2;

    // The CPU keeps the RAM while it is draining towards a halt.
    function automatic logic [1:0] owner_of(state_t s);
        case (s)
            ST_RUN, ST_DRAIN: owner_of = OWN_CPU;
            ST_HALTED:        owner_of = OWN_DIAG;
            default:          owner_of = OWN_LOADER;
        endcase
    endfunction

endpackage

// File: rtl/phi2_edge_sync.sv
// Brings the asynchronous CPU phi2 clock into the clk domain and emits a
// one-cycle pulse for each falling edge.
module phi2_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic phi2,
    output logic fall
);
    logic r_meta;
    logic r_sync;
    logic r_dly;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_dly  <= 1'b0;
        end else begin
            r_meta <= phi2;
            r_sync <= r_meta;
            r_dly  <= r_sync;
        end
    end

    assign fall = r_dly & ~r_sync;

endmodule

// File: rtl/ram_access_arbiter.sv
// Arbitrates one RAM between the flash loader, the CPU and a diagnostics port,
// with optional video-RAM write windows (macro ROMULATOR_VRAM_WINDOW_EN).
module ram_access_arbiter
    import romulator_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int NUM_WIN    = DEF_NUM_WIN,
    parameter int HALT_EDGES = DEF_HALT_EDGES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_done,
    input  logic [ADDR_W-1:0]         ld_addr,
    input  logic [DATA_W-1:0]         ld_data,
    input  logic                      ld_cs,
    input  logic                      ld_we,
    input  logic                      phi2,
    input  logic [ADDR_W-1:0]         cpu_addr,
    input  logic [DATA_W-1:0]         cpu_data,
    input  logic                      cpu_cs,
    input  logic                      cpu_we,
    input  logic                      diag_halt_req,
    input  logic [ADDR_W-1:0]         diag_addr,
    input  logic [DATA_W-1:0]         diag_data,
    input  logic                      diag_cs,
    input  logic                      diag_we,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic [DATA_W-1:0]         ram_data,
    output logic                      ram_cs,
    output logic                      ram_we,
    output logic                      rdy,
    output logic                      halt_ack,
    output logic                      bus_oe,
    output logic [1:0]                owner,
    input  logic [NUM_WIN*ADDR_W-1:0] win_start,
    input  logic [NUM_WIN*ADDR_W-1:0] win_end,
    output logic [NUM_WIN-1:0]        win_we,
    output logic [ADDR_W-1:0]         win_addr,
    output logic [DATA_W-1:0]         win_data
);
    localparam int CNT_W = (HALT_EDGES < 2) ? 1 : $clog2(HALT_EDGES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALT_EDGES - 1);

    state_t           r_state;
    state_t           w_nxt_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_nxt_cnt;
    logic             w_fall;

    phi2_edge_sync u_phi2_sync (
        .clk  (clk),
        .rst  (rst),
        .phi2 (phi2),
        .fall (w_fall)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_LOAD;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        case (r_state)
            ST_LOAD: begin
                if (load_done) w_nxt_state = ST_RUN;
            end
            ST_RUN: begin
                if (diag_halt_req) begin
                    w_nxt_state = ST_DRAIN;
                    w_nxt_cnt   = '0;
                end
            end
            ST_DRAIN: begin
                // A withdrawn request abandons the drain even if an edge lands now.
                if (!diag_halt_req) begin
                    w_nxt_state = ST_RUN;
                    w_nxt_cnt   = '0;
                end else if (w_fall) begin
                    if (r_cnt == CNT_LAST) begin
                        w_nxt_state = ST_HALTED;
                        w_nxt_cnt   = '0;
                    end else begin
                        w_nxt_cnt = r_cnt + 1'b1;
                    end
                end
            end
            ST_HALTED: begin
                if (!diag_halt_req) w_nxt_state = ST_RUN;
            end
            default: w_nxt_state = ST_LOAD;
        endcase
    end

    always_comb begin
        ram_addr = ld_addr;
        ram_data = ld_data;
        ram_cs   = ld_cs;
        ram_we   = ld_we;
        case (r_state)
            ST_RUN, ST_DRAIN: begin
                ram_addr = cpu_addr;
                ram_data = cpu_data;
                ram_cs   = cpu_cs;
                ram_we   = cpu_we;
            end
            ST_HALTED: begin
                ram_addr = diag_addr;
                ram_data = diag_data;
                ram_cs   = diag_cs;
                ram_we   = diag_we;
            end
            default: ;
        endcase
    end

    assign owner    = owner_of(r_state);
    assign rdy      = (r_state == ST_RUN);
    assign halt_ack = (r_state == ST_HALTED);
    assign bus_oe   = (owner == OWN_CPU) & cpu_cs & ~cpu_we;

`ifdef ROMULATOR_VRAM_WINDOW_EN
    logic [NUM_WIN-1:0] w_sel;
    logic [ADDR_W-1:0]  w_off;
    logic               w_found;
    logic [ADDR_W-1:0]  w_ws;
    logic [ADDR_W-1:0]  w_we_end;
    logic [NUM_WIN-1:0] r_win_we;
    logic [ADDR_W-1:0]  r_win_addr;
    logic [DATA_W-1:0]  r_win_data;

    // Lowest-index hit wins; an empty or inverted range never matches.
    always_comb begin
        w_sel    = '0;
        w_off    = '0;
        w_found  = 1'b0;
        w_ws     = '0;
        w_we_end = '0;
        for (int i = 0; i < NUM_WIN; i++) begin
            w_ws     = win_start[i*ADDR_W +: ADDR_W];
            w_we_end = win_end[i*ADDR_W +: ADDR_W];
            if (!w_found && (w_ws < w_we_end) &&
                (ram_addr >= w_ws) && (ram_addr < w_we_end)) begin
                w_found  = 1'b1;
                w_sel[i] = 1'b1;
                w_off    = ram_addr - w_ws;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_win_we   <= '0;
            r_win_addr <= '0;
            r_win_data <= '0;
        end else begin
            r_win_we   <= w_sel & {NUM_WIN{ram_we & ram_cs}};
            r_win_addr <= w_off;
            r_win_data <= ram_data;
        end
    end

    assign win_we   = r_win_we;
    assign win_addr = r_win_addr;
    assign win_data = r_win_data;
`else
    assign win_we   = '0;
    assign win_addr = '0;
    assign win_data = '0;
`endif

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter; window checks follow whichever build
// (ROMULATOR_VRAM_WINDOW_EN defined or not) is being simulated.
module tb_ram_access_arbiter;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int NW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load_done = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;
    logic          ld_cs = 1'b0, ld_we = 1'b0;
    logic          phi2 = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_data = '0;
    logic          cpu_cs = 1'b0, cpu_we = 1'b0;
    logic          diag_halt_req = 1'b0;
    logic [AW-1:0] diag_addr = '0;
    logic [DW-1:0] diag_data = '0;
    logic          diag_cs = 1'b0, diag_we = 1'b0;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic          ram_cs, ram_we, rdy, halt_ack, bus_oe;
    logic [1:0]    owner;
    logic [NW*AW-1:0] win_start = '0, win_end = '0;
    logic [NW-1:0] win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_data;

    int total = 0;
    int bad = 0;

    typedef struct {
        string         tag;
        logic [NW-1:0] we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            chk_addr;
    } win_exp_t;
    win_exp_t sb[$];

    ram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NUM_WIN(NW), .HALT_EDGES(2)) dut (
        .clk(clk), .rst(rst), .load_done(load_done),
        .ld_addr(ld_addr), .ld_data(ld_data), .ld_cs(ld_cs), .ld_we(ld_we),
        .phi2(phi2), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_cs(cpu_cs), .cpu_we(cpu_we),
        .diag_halt_req(diag_halt_req), .diag_addr(diag_addr), .diag_data(diag_data),
        .diag_cs(diag_cs), .diag_we(diag_we),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_cs(ram_cs), .ram_we(ram_we),
        .rdy(rdy), .halt_ack(halt_ack), .bus_oe(bus_oe), .owner(owner),
        .win_start(win_start), .win_end(win_end),
        .win_we(win_we), .win_addr(win_addr), .win_data(win_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic phi2_fall();
        phi2 = 1'b1;
        repeat (3) tick();
        phi2 = 1'b0;
        repeat (3) tick();
    endtask

    // Drive a CPU access and queue what the window port must show one clk later.
    task automatic cpu_write(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic cs, input logic [NW-1:0] we_exp,
                             input logic [AW-1:0] off_exp, input bit chk);
        win_exp_t e;
        cpu_addr = a; cpu_data = d; cpu_cs = cs; cpu_we = 1'b1;
        e.tag = tag;
`ifdef ROMULATOR_VRAM_WINDOW_EN
        e.we = we_exp; e.addr = off_exp; e.data = d; e.chk_addr = chk;
`else
        e.we = '0; e.addr = '0; e.data = '0; e.chk_addr = 1'b1;
`endif
        sb.push_back(e);
        tick();
        e = sb.pop_front();
        check({e.tag, "_we"}, 32'(win_we), 32'(e.we));
        if (e.chk_addr) begin
            check({e.tag, "_addr"}, 32'(win_addr), 32'(e.addr));
            check({e.tag, "_data"}, 32'(win_data), 32'(e.data));
        end
    endtask

    initial begin
        bit seen;
        // Reset state
        #2;
        check("rst_rdy", 32'(rdy), 0);
        check("rst_halt_ack", 32'(halt_ack), 0);
        check("rst_owner", 32'(owner), 0);
        check("rst_win_we", 32'(win_we), 0);
        check("rst_win_addr", 32'(win_addr), 0);
        check("rst_win_data", 32'(win_data), 0);
        #10 rst = 1'b1;

        // Loader owns the RAM
        ld_addr = 16'h1234; ld_data = 8'h5A; ld_cs = 1'b1; ld_we = 1'b1;
        tick();
        check("ld_ram_addr", 32'(ram_addr), 32'h1234);
        check("ld_ram_we", 32'(ram_we), 1);
        check("ld_ram_data", 32'(ram_data), 32'h5A);
        check("ld_rdy", 32'(rdy), 0);
        cpu_cs = 1'b1; cpu_we = 1'b0; #1;
        check("ld_bus_oe", 32'(bus_oe), 0);
        load_done = 1'b1;
        #1 check("ld_rdy_pre_edge", 32'(rdy), 0);
        tick();
        check("run_rdy", 32'(rdy), 1);
        check("run_owner", 32'(owner), 1);
        load_done = 1'b0;
        tick();
        check("run_ignore_load_done", 32'(owner), 1);
        cpu_addr = 16'h0042; #1;
        check("run_ram_addr", 32'(ram_addr), 32'h0042);
        check("run_bus_oe_read", 32'(bus_oe), 1);
        cpu_we = 1'b1; #1;
        check("run_bus_oe_write", 32'(bus_oe), 0);

        // Windows: win0=[8000,8400), win1 unused (empty)
        win_start = {16'h0000, 16'h8000}; win_end = {16'h0000, 16'h8400};
        cpu_write("w0_hit", 16'h8010, 8'hA1, 1'b1, 2'b01, 16'h0010, 1'b1);
        cpu_write("w0_end_excl", 16'h8400, 8'hA2, 1'b1, 2'b00, 16'h0000, 1'b0);
        cpu_write("w0_first", 16'h8000, 8'hA3, 1'b1, 2'b01, 16'h0000, 1'b1);
        cpu_write("w0_no_cs", 16'h8020, 8'hA4, 1'b0, 2'b00, 16'h0020, 1'b1);
        // Overlap: lowest index wins
        win_start = {16'h8800, 16'h8000}; win_end = {16'h8900, 16'h9000};
        cpu_write("ovl_low", 16'h8810, 8'hB1, 1'b1, 2'b01, 16'h0810, 1'b1);
        // Window 0 empty (start=end) -> window 1 takes it
        win_start = {16'h8800, 16'h8000}; win_end = {16'h8900, 16'h8000};
        cpu_write("w0_empty_w1", 16'h8810, 8'hB2, 1'b1, 2'b10, 16'h0010, 1'b1);
        cpu_write("w0_empty_miss", 16'h8000, 8'hB3, 1'b1, 2'b00, 16'h0000, 1'b0);
        // Window 0 inverted -> disabled
        win_start = {16'h0000, 16'h9000}; win_end = {16'h0000, 16'h8000};
        cpu_write("w0_inverted", 16'h8800, 8'hB4, 1'b1, 2'b00, 16'h0000, 1'b0);
        cpu_cs = 1'b0; cpu_we = 1'b0;

        // Halt request with two phi2 edges
        cpu_addr = 16'h0777; diag_addr = 16'h4321; diag_data = 8'hC3;
        diag_cs = 1'b1; diag_we = 1'b1;
        diag_halt_req = 1'b1;
        tick();
        check("drain_rdy", 32'(rdy), 0);
        check("drain_owner", 32'(owner), 1);
        check("drain_ram_addr", 32'(ram_addr), 32'h0777);
        phi2_fall();
        repeat (3) tick();
        check("drain_one_edge_ack", 32'(halt_ack), 0);
        phi2_fall();
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            if (halt_ack) seen = 1'b1; else tick();
        end
        check("halt_ack_after_2", 32'(seen), 1);
        check("halt_owner", 32'(owner), 2);
        check("halt_ram_addr", 32'(ram_addr), 32'h4321);
        check("halt_ram_data", 32'(ram_data), 32'hC3);
        check("halt_rdy", 32'(rdy), 0);
        diag_halt_req = 1'b0;
        #1 check("halt_ack_pre_edge", 32'(halt_ack), 1);
        tick();
        check("unhalt_ack", 32'(halt_ack), 0);
        check("unhalt_rdy", 32'(rdy), 1);

        // Aborted drain: one edge, request dropped
        diag_halt_req = 1'b1;
        tick();
        phi2_fall();
        check("abort_ack_mid", 32'(halt_ack), 0);
        diag_halt_req = 1'b0;
        tick();
        check("abort_rdy", 32'(rdy), 1);
        check("abort_ack", 32'(halt_ack), 0);
        check("abort_owner", 32'(owner), 1);
        // Counter must restart: one more edge alone must not halt
        diag_halt_req = 1'b1;
        tick();
        phi2_fall();
        repeat (3) tick();
        check("cnt_cleared", 32'(halt_ack), 0);
        phi2_fall();
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            if (halt_ack) seen = 1'b1; else tick();
        end
        check("rehalt_ack", 32'(seen), 1);

        // Async reset while halted, away from any clk edge
        #2 rst = 1'b0;
        #1;
        check("arst_halt_ack", 32'(halt_ack), 0);
        check("arst_owner", 32'(owner), 0);
        check("arst_rdy", 32'(rdy), 0);
        check("arst_ram_addr", 32'(ram_addr), 32'h1234);
        diag_halt_req = 1'b0;
        #10 rst = 1'b1;
        tick();
        check("restart_owner", 32'(owner), 0);
        check("restart_rdy", 32'(rdy), 0);
        check("restart_win_we", 32'(win_we), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
